// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end.
//   fetch_state_t    : fetch FSM encoding (IDLE, REQ, WAIT, DROP)
//   NOP_INSTR        : canonical RISC-V NOP (addi x0, x0, 0) used for bubbles/flushes
//   RESET_PC_DEFAULT : default first fetch address after reset
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register between fetch and decode.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : kill the stage content (valid=0, instr=NOP); beats stall
//   stall       : decode cannot accept; hold everything
//   load        : a real instruction is presented on instr_in/pc_in this cycle
//   instr_in    : instruction word
//   pc_in       : PC of instr_in
//   instr_d     : registered instruction (NOP when empty)
//   pc_d        : registered PC
//   pc_plus4_d  : registered PC + 4 (wraps modulo 2^WIDTH)
//   valid_d     : registered instruction is real
// A cycle that is neither stalled nor loaded becomes a bubble; the PC fields
// keep their old value in a bubble since decode ignores them when !valid_d.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             stall,
  input  logic             load,
  input  logic [WIDTH-1:0] instr_in,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_plus4_d,
  output logic             valid_d
);

  logic [WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
  logic             ifid_valid_q, ifid_valid_d;

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (flush) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = WIDTH'(NOP_INSTR);
    end else if (!stall) begin
      if (load) begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = instr_in;
        ifid_pc_d    = pc_in;
        ifid_pc4_d   = pc_in + WIDTH'(4);
      end else begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = WIDTH'(NOP_INSTR);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_q <= WIDTH'(NOP_INSTR);
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign instr_d    = ifid_instr_q;
  assign pc_d       = ifid_pc_q;
  assign pc_plus4_d = ifid_pc4_q;
  assign valid_d    = ifid_valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC select, instruction-memory handshake,
// one-entry skid buffer and the IF/ID register feeding decode.
//   clk, rst_n        : clock, asynchronous active-low reset
//   pc_src, jump_src  : redirect request; target select (1: alu_result, 0: pc_target)
//   pc_target         : PC+imm from execute
//   alu_result        : JALR sum from the ALU (low two bits forced to 0)
//   stall_d           : decode cannot accept; hold IF/ID
//   imem_req/addr     : request valid / word address
//   imem_gnt          : request accepted this cycle
//   imem_rvalid/rdata : response valid / instruction word (at most one outstanding)
//   instr_d, pc_d, pc_plus4_d, valid_d : IF/ID register outputs to decode
//   dbg_state         : current fetch FSM state, for observation only
//
// Handshake: imem_req rises in REQ and stays high with a stable imem_addr
// until the cycle imem_gnt is seen; only a redirect may change imem_addr
// while imem_req is high. Exactly one response (imem_rvalid) follows each
// grant, no earlier than the cycle after the grant.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_src,
  input  logic             jump_src,
  input  logic [WIDTH-1:0] pc_target,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             stall_d,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_plus4_d,
  output logic             valid_d,
  output fetch_state_t     dbg_state
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_f_q, pc_f_d;
  logic             buf_valid_q, buf_valid_d;
  logic [WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic [WIDTH-1:0] buf_pc_q, buf_pc_d;

  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] fetched_pc;
  logic             ifid_load;
  logic [WIDTH-1:0] ifid_instr;
  logic [WIDTH-1:0] ifid_pc;

  // Both sources are word-aligned so imem_addr[1:0] stays 0.
  assign redirect_pc = jump_src ? {alu_result[WIDTH-1:2], 2'b00}
                                : {pc_target[WIDTH-1:2], 2'b00};

  // pc_f advanced by 4 at grant, so the outstanding word belongs to pc_f-4.
  // A redirect while outstanding always discards that word, so this never
  // sees a redirected pc_f when the word is actually used.
  assign fetched_pc = pc_f_q - WIDTH'(4);

  assign imem_req  = (state_q == REQ) && !buf_valid_q;
  assign imem_addr = pc_f_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    ifid_load   = 1'b0;
    ifid_instr  = imem_rdata;
    ifid_pc     = fetched_pc;

    case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        if (imem_gnt) begin
          pc_f_d  = pc_f_q + WIDTH'(4);
          state_d = pc_src ? DROP : WAIT;
        end
      end

      WAIT: begin
        if (buf_valid_q) begin
          // Response already parked; no request until decode takes it.
          if (!stall_d) begin
            ifid_load   = 1'b1;
            ifid_instr  = buf_instr_q;
            ifid_pc     = buf_pc_q;
            buf_valid_d = 1'b0;
            state_d     = REQ;
          end
        end else if (imem_rvalid) begin
          if (pc_src) begin
            state_d = REQ;
          end else if (!stall_d) begin
            ifid_load = 1'b1;
            state_d   = REQ;
          end else begin
            buf_valid_d = 1'b1;
            buf_instr_d = imem_rdata;
            buf_pc_d    = fetched_pc;
          end
        end else if (pc_src) begin
          state_d = DROP;
        end
      end

      DROP: begin
        if (imem_rvalid) state_d = REQ;
      end

      default: state_d = IDLE;
    endcase

    // Redirect overrides PC selection from any state and kills the buffer;
    // the IF/ID flush is driven by pc_src directly.
    if (pc_src) begin
      pc_f_d      = redirect_pc;
      buf_valid_d = 1'b0;
      if (state_q == WAIT && buf_valid_q) state_d = REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_f_q      <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_instr_q <= WIDTH'(NOP_INSTR);
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  if_id_reg #(.WIDTH(WIDTH)) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (pc_src),
    .stall     (stall_d),
    .load      (ifid_load),
    .instr_in  (ifid_instr),
    .pc_in     (ifid_pc),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc_plus4_d(pc_plus4_d),
    .valid_d   (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction
// model (next PC, one in-flight fetch, queue of words owed to decode).
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         pc_src = 1'b0, jump_src = 1'b0, stall_d = 1'b0;
  logic         imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [W-1:0] pc_target = '0, alu_result = '0, imem_rdata = '0;
  logic         imem_req, valid_d;
  logic [W-1:0] imem_addr, instr_d, pc_d, pc_plus4_d;
  fetch_state_t dbg_state;

  fetch_stage #(.WIDTH(W), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .jump_src(jump_src),
    .pc_target(pc_target), .alu_result(alu_result), .stall_d(stall_d),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0, failures = 0, cyc = 0;
  logic [W-1:0] exp_q[$];    // PCs of words accepted from memory, owed to decode
  logic [W-1:0] grant_q[$];  // addresses seen granted
  logic         m_first, m_inflight, m_drop, m_valid;
  logic [W-1:0] m_next_pc, m_infl_pc, m_instr, m_pc;
  logic         mem_busy = 1'b0;
  logic [W-1:0] mem_addr = '0;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_first = 1'b1; m_inflight = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
    m_next_pc = '0; m_infl_pc = '0; m_instr = NOP_INSTR; m_pc = '0;
    exp_q.delete();
    mem_busy = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; stall_d = 1'b0; pc_src = 1'b0;
  endtask

  // ---------------- driver + compare + model, one cycle ----------------
  // Called at a negedge: compare outputs, drive inputs, advance the model.
  task automatic step(input bit g, input bit rv, input bit st, input bit ps, input bit js,
                      input logic [W-1:0] pt, input logic [W-1:0] ar, input bit force_rv);
    logic         exp_req;
    logic [W-1:0] tgt;
    exp_req = !m_first && !m_inflight && (exp_q.size() == 0);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_next_pc);
    chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
    chk("instr_d", instr_d, m_instr);
    if (m_valid) begin
      chk("pc_d", pc_d, m_pc);
      chk("pc_plus4_d", pc_plus4_d, m_pc + 32'd4);
    end

    imem_gnt    = g;
    stall_d     = st;
    pc_src      = ps;
    jump_src    = js;
    pc_target   = {pt[W-1:2], 2'b00};
    alu_result  = ar;
    imem_rvalid = (rv && mem_busy) || force_rv;
    imem_rdata  = mem_word(mem_addr);

    // memory side reacts to what the DUT actually asked for
    if (imem_rvalid) mem_busy = 1'b0;
    if (imem_req && g) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      grant_q.push_back(imem_addr);
    end

    tgt = js ? {ar[W-1:2], 2'b00} : {pt[W-1:2], 2'b00};
    if (ps) begin
      m_valid = 1'b0; m_instr = NOP_INSTR; exp_q.delete();
    end else begin
      if (imem_rvalid && m_inflight && !m_drop) exp_q.push_back(m_infl_pc);
      if (!st) begin
        if (exp_q.size() > 0) begin
          m_pc = exp_q.pop_front(); m_valid = 1'b1; m_instr = mem_word(m_pc);
        end else begin
          m_valid = 1'b0; m_instr = NOP_INSTR;
        end
      end
    end
    if (imem_rvalid && m_inflight) m_inflight = 1'b0;
    else if (ps && m_inflight) m_drop = 1'b1;
    if (exp_req && g) begin
      m_inflight = 1'b1; m_infl_pc = m_next_pc; m_drop = ps;
    end
    if (ps) m_next_pc = tgt;
    else if (exp_req && g) m_next_pc = m_next_pc + 32'd4;
    m_first = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic goto_req();
    for (int i = 0; i < 10 && !imem_req; i++) step(0, 1, 0, 0, 0, '0, '0, 0);
    chk("goto_req", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic random_phase(input int n);
    bit           g, rv, st, ps, js;
    logic [W-1:0] pt, ar;
    for (int i = 0; i < n; i++) begin
      g  = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 11) == 0);
      js = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) pt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else pt = 32'($urandom_range(0, 255) * 4);
      ar = $urandom();
      step(g, rv, st, ps, js, pt, ar, 0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  int first_valid;
  int gi;

  initial begin
    model_reset();
    @(negedge clk);
    chk("rst_valid", {31'b0, valid_d}, 32'd0);
    chk("rst_instr", instr_d, 32'h0000_0013);
    chk("rst_pc", pc_d, 32'd0);
    chk("rst_pc4", pc_plus4_d, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: back-to-back fetch, addresses 0,4,8
    grant_q.delete();
    first_valid = -1;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 0, '0, '0, 0);
      if (valid_d && first_valid < 0) begin
        first_valid = i + 1;
        chk("t1_first_pc", pc_d, 32'h0);
        chk("t1_first_pc4", pc_plus4_d, 32'h4);
        chk("t1_first_instr", instr_d, mem_word(32'h0));
      end
    end
    chk("t1_latency", first_valid, 32'd3);
    chk("t1_addr0", grant_q[0], 32'h0);
    chk("t1_addr1", grant_q[1], 32'h4);
    chk("t1_addr2", grant_q[2], 32'h8);

    // 2: branch while WAIT -> DROP, stale response discarded
    goto_req();
    step(1, 0, 0, 0, 0, '0, '0, 0);
    step(0, 0, 0, 1, 0, 32'h40, '0, 0);
    chk("t2_state", dbg_state, DROP);
    chk("t2_flush_valid", {31'b0, valid_d}, 32'd0);
    step(0, 1, 0, 0, 0, '0, '0, 0);
    chk("t2_req", {31'b0, imem_req}, 32'd1);
    chk("t2_addr", imem_addr, 32'h40);
    chk("t2_stale_valid", {31'b0, valid_d}, 32'd0);

    // 3: JALR target 0x103 -> 0x100
    step(0, 0, 0, 1, 1, '0, 32'h103, 0);
    chk("t3_addr", imem_addr, 32'h100);

    // 4: stall for 3 cycles as the response arrives
    step(1, 0, 0, 0, 0, '0, '0, 0);
    step(0, 1, 1, 0, 0, '0, '0, 0);
    chk("t4_noreq_a", {31'b0, imem_req}, 32'd0);
    step(0, 0, 1, 0, 0, '0, '0, 0);
    chk("t4_noreq_b", {31'b0, imem_req}, 32'd0);
    step(0, 0, 1, 0, 0, '0, '0, 0);
    chk("t4_noreq_c", {31'b0, imem_req}, 32'd0);
    chk("t4_held", {31'b0, valid_d}, 32'd0);
    step(0, 0, 0, 0, 0, '0, '0, 0);
    chk("t4_valid", {31'b0, valid_d}, 32'd1);
    chk("t4_pc", pc_d, 32'h100);
    chk("t4_instr", instr_d, mem_word(32'h100));

    // 5: flush beats stall
    step(0, 0, 1, 1, 0, 32'h200, '0, 0);
    chk("t5_valid", {31'b0, valid_d}, 32'd0);
    chk("t5_instr", instr_d, 32'h0000_0013);

    // PC wrap at the top of the address space
    step(0, 0, 0, 1, 0, 32'hFFFF_FFF8, '0, 0);
    step(1, 0, 0, 0, 0, '0, '0, 0);
    step(0, 1, 0, 0, 0, '0, '0, 0);
    chk("wrap_addr_a", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_a", pc_d, 32'hFFFF_FFF8);
    step(1, 0, 0, 0, 0, '0, '0, 0);
    step(0, 1, 0, 0, 0, '0, '0, 0);
    chk("wrap_addr_b", imem_addr, 32'h0);
    chk("wrap_pc_b", pc_d, 32'hFFFF_FFFC);
    chk("wrap_pc4_b", pc_plus4_d, 32'h0);

    // 6: async reset mid-WAIT, late response ignored, restart at 0
    goto_req();
    step(1, 0, 0, 0, 0, '0, '0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'b0, valid_d}, 32'd0);
    chk("t6_instr", instr_d, 32'h0000_0013);
    chk("t6_pc", pc_d, 32'd0);
    chk("t6_pc4", pc_plus4_d, 32'd0);
    chk("t6_req", {31'b0, imem_req}, 32'd0);
    chk("t6_state", dbg_state, IDLE);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, '0, '0, 1);
    gi = grant_q.size();
    step(1, 0, 0, 0, 0, '0, '0, 0);
    chk("t6_restart_addr", grant_q[gi], 32'h0);
    step(0, 1, 0, 0, 0, '0, '0, 0);
    chk("t6_restart_valid", {31'b0, valid_d}, 32'd1);
    chk("t6_restart_pc", pc_d, 32'h0);

    // randomized traffic
    random_phase(3000);
    step(0, 0, 0, 0, 0, '0, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
